paddle_controller: RTL and testbench

Upstream stage of the ball controller. Converts one player's raw up/down buttons into the registered paddle top coordinate `y_pad` consumed by the ball controller and the paddle draw stage. Synchronises and debounces the buttons, runs a three-state movement FSM with tick-based acceleration, and clamps the paddle inside the visible field. One instance is used per side.

---
 rtl/paddle_controller.sv | 179 +++++++++++++++++
 tb/tb_paddle_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_controller.sv
// paddle_controller: button sync/debounce, IDLE/UP/DOWN FSM, accelerating clamped paddle.
// Define PADDLE_AI_EN to add ai_mode/y_ball automatic tracking of the ball.
module paddle_controller #(
  parameter int SCREEN_H        = 768,
  parameter int PAD_H           = 72,
  parameter int SPEED_MIN       = 1,
  parameter int SPEED_MAX       = 6,
  parameter int ACCEL_TICKS     = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        freeze,
`ifdef PADDLE_AI_EN
  input  logic        ai_mode,
  input  logic [10:0] y_ball,
`endif
  output logic [9:0]  y_pad,
  output logic        moving
);

  localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - PAD_H);
  localparam logic [9:0] Y_RST   = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [4:0] DB_LAST = 5'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] AC_LAST = 4'(ACCEL_TICKS - 1);
  localparam logic [2:0] SPD_LO  = 3'(SPEED_MIN);
  localparam logic [2:0] SPD_HI  = 3'(SPEED_MAX);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  up_sync;
  logic [1:0]  dn_sync;
  logic [4:0]  up_cnt;
  logic [4:0]  dn_cnt;
  logic        up_db;
  logic        down_db;
  logic        want_up;
  logic        want_dn;
  logic [2:0]  speed;
  logic [3:0]  tick_cnt;
  logic [10:0] y_sum;
  logic [9:0]  y_up;
  logic [9:0]  y_dn;

  // Two-flop synchronisers for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_down};
    end
  end

  // Up debouncer: accept a new level after it persists long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_db  <= 1'b0;
      up_cnt <= '0;
    end else if (up_sync[1] == up_db) begin
      up_cnt <= '0;
    end else if (up_cnt == DB_LAST) begin
      up_db  <= up_sync[1];
      up_cnt <= '0;
    end else begin
      up_cnt <= up_cnt + 5'd1;
    end
  end

  // Down debouncer: same scheme as the up button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      down_db <= 1'b0;
      dn_cnt  <= '0;
    end else if (dn_sync[1] == down_db) begin
      dn_cnt <= '0;
    end else if (dn_cnt == DB_LAST) begin
      down_db <= dn_sync[1];
      dn_cnt  <= '0;
    end else begin
      dn_cnt <= dn_cnt + 5'd1;
    end
  end

`ifdef PADDLE_AI_EN
  logic [11:0] ball_c;
  logic [11:0] pad_lo;
  logic [11:0] pad_hi;

  // Movement request: ball-centre tracking in AI mode, buttons otherwise.
  always_comb begin
    ball_c  = {1'b0, y_ball} + 12'd7;
    pad_lo  = {2'b0, y_pad} + 12'd35;
    pad_hi  = {2'b0, y_pad} + 12'd37;
    want_up = up_db;
    want_dn = down_db;
    if (ai_mode) begin
      want_up = (ball_c < pad_lo);
      want_dn = (ball_c > pad_hi);
    end
  end
`else
  // Movement request comes straight from the debounced buttons.
  always_comb begin
    want_up = up_db;
    want_dn = down_db;
  end
`endif

  // Next state: freeze or conflicting requests park the paddle.
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      (!freeze && want_up && !want_dn): state_d = UP;
      (!freeze && want_dn && !want_up): state_d = DOWN;
      default:                          state_d = IDLE;
    endcase
  end

  // State register with the registered moving flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      moving  <= 1'b0;
    end else begin
      state_q <= state_d;
      moving  <= (state_d != IDLE);
    end
  end

  // Acceleration: restart on any state change, step every ACCEL_TICKS ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed    <= SPD_LO;
      tick_cnt <= '0;
    end else if (state_d != state_q || state_d == IDLE) begin
      speed    <= SPD_LO;
      tick_cnt <= '0;
    end else if (timing_tick) begin
      if (tick_cnt == AC_LAST) begin
        tick_cnt <= '0;
        if (speed < SPD_HI) speed <= speed + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + 4'd1;
      end
    end
  end

  // Clamped candidate positions; the sum is 11 bits so it cannot wrap.
  always_comb begin
    y_sum = {1'b0, y_pad} + {8'b0, speed};
    y_dn  = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[9:0];
    y_up  = (y_pad < {7'b0, speed}) ? '0 : y_pad - {7'b0, speed};
  end

  // Position update once per frame tick using the registered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_pad <= Y_RST;
    end else if (timing_tick && !freeze) begin
      case (state_q)
        UP:      y_pad <= y_up;
        DOWN:    y_pad <= y_dn;
        default: y_pad <= y_pad;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: directed scenarios plus random stimulus
// compared against a behavioural model of the paddle rules.
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timing_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] y_pad;
  logic       moving;
`ifdef PADDLE_AI_EN
  logic        ai_mode = 1'b0;
  logic [10:0] y_ball = '0;
`endif

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  paddle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .freeze      (freeze),
`ifdef PADDLE_AI_EN
    .ai_mode     (ai_mode),
    .y_ball      (y_ball),
`endif
    .y_pad       (y_pad),
    .moving      (moving)
  );

  // Model: sync pipeline, run-length debounce, direction,
  // ticks spent in the current run, position.
  int m_s1u, m_s2u, m_accu, m_runu;
  int m_s1d, m_s2d, m_accd, m_rund;
  int m_dir;
  int m_ticks;
  int m_y;

  task automatic model_reset();
    m_s1u = 0; m_s2u = 0; m_accu = 0; m_runu = 0;
    m_s1d = 0; m_s2d = 0; m_accd = 0; m_rund = 0;
    m_dir = 0; m_ticks = 0; m_y = 348;
  endtask

  task automatic model_step(input logic u, input logic d,
                            input logic f, input logic t);
    int spd;
    int nd;
    spd = 1 + m_ticks / 8;
    if (spd > 6) spd = 6;
    if (f || m_accu == m_accd) nd = 0;
    else nd = (m_accu != 0) ? 1 : 2;
    if (t && !f) begin
      if (m_dir == 1) m_y = (m_y < spd) ? 0 : m_y - spd;
      if (m_dir == 2) m_y = (m_y + spd > 696) ? 696 : m_y + spd;
    end
    if (nd != m_dir || nd == 0) m_ticks = 0;
    else if (t) m_ticks++;
    m_dir = nd;
    if (m_s2u != m_accu) begin
      m_runu++;
      if (m_runu == 16) begin m_accu = m_s2u; m_runu = 0; end
    end else m_runu = 0;
    if (m_s2d != m_accd) begin
      m_rund++;
      if (m_rund == 16) begin m_accd = m_s2d; m_rund = 0; end
    end else m_rund = 0;
    m_s2u = m_s1u; m_s1u = int'(u);
    m_s2d = m_s1d; m_s1d = int'(d);
  endtask

  task automatic cyc(input logic u, input logic d,
                     input logic f, input logic t);
    @(negedge clk);
    btn_up = u; btn_down = d; freeze = f; timing_tick = t;
    @(posedge clk);
    #1;
    model_step(u, d, f, t);
  endtask

  task automatic frames(input logic u, input logic d,
                        input logic f, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(u, d, f, 1'b1);
      repeat (3) cyc(u, d, f, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_up = 0; btn_down = 0; freeze = 0; timing_tick = 0;
    rst = 0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (19) cyc(0, 1, 0, 0);
    frames(0, 1, 0, 3);
    @(negedge clk);
    btn_down = 0;
    rst = 0;
    #1;
    tests_run++;
    if (y_pad !== 10'd348 || moving !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: y_pad=%0d moving=%b want 348/0",
               y_pad, moving);
    end
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1;
    frames(0, 0, 0, 10);
    tests_run++;
    if (y_pad !== 10'd348) begin
      fails++;
      $display("FAIL reset_hold_y: y_pad=%0d want 348", y_pad);
    end
    tests_run++;
    if (moving !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_moving: moving=%b want 0", moving);
    end
  endtask

  task automatic test_accel();
    do_reset();
    repeat (18) cyc(1, 0, 0, 0);
    tests_run++;
    if (moving !== 1'b0) begin
      fails++;
      $display("FAIL accel_latency_early: moving=%b want 0", moving);
    end
    cyc(1, 0, 0, 0);
    tests_run++;
    if (moving !== 1'b1) begin
      fails++;
      $display("FAIL accel_latency: moving=%b want 1", moving);
    end
    frames(1, 0, 0, 8);
    tests_run++;
    if (y_pad !== 10'd340) begin
      fails++;
      $display("FAIL accel_8: y_pad=%0d want 340", y_pad);
    end
    frames(1, 0, 0, 8);
    tests_run++;
    if (y_pad !== 10'd324 || moving !== 1'b1) begin
      fails++;
      $display("FAIL accel_16: y_pad=%0d moving=%b want 324/1",
               y_pad, moving);
    end
  endtask

  task automatic test_saturation();
    int prev;
    int step;
    int max_step;
    int bad;
    do_reset();
    max_step = 0;
    bad = 0;
    repeat (19) cyc(0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      prev = int'(y_pad);
      frames(0, 1, 0, 1);
      step = int'(y_pad) - prev;
      if (step > max_step) max_step = step;
      if (step < 0 || step > 6 || y_pad > 10'd696) bad++;
    end
    tests_run++;
    if (max_step != 6) begin
      fails++;
      $display("FAIL sat_speed: max step=%0d want 6", max_step);
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sat_range: bad frames=%0d want 0", bad);
    end
    tests_run++;
    if (y_pad !== 10'd696) begin
      fails++;
      $display("FAIL sat_clamp: y_pad=%0d want 696", y_pad);
    end
  endtask

  task automatic test_debounce();
    int bad;
    do_reset();
    bad = 0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        cyc(i < 10, 0, 0, (i % 4) == 0);
        if (y_pad !== 10'd348 || moving !== 1'b0) bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL debounce_pulse: bad cycles=%0d want 0", bad);
    end
    frames(1, 1, 0, 15);
    tests_run++;
    if (y_pad !== 10'd348 || moving !== 1'b0) begin
      fails++;
      $display("FAIL debounce_both: y_pad=%0d moving=%b want 348/0",
               y_pad, moving);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    repeat (19) cyc(1, 0, 0, 0);
    frames(1, 0, 0, 10);
    tests_run++;
    if (y_pad !== 10'd336) begin
      fails++;
      $display("FAIL freeze_pre: y_pad=%0d want 336", y_pad);
    end
    cyc(1, 0, 1, 0);
    tests_run++;
    if (moving !== 1'b0) begin
      fails++;
      $display("FAIL freeze_moving: moving=%b want 0", moving);
    end
    frames(1, 0, 1, 3);
    tests_run++;
    if (y_pad !== 10'd336) begin
      fails++;
      $display("FAIL freeze_hold: y_pad=%0d want 336", y_pad);
    end
    cyc(1, 0, 0, 0);
    frames(1, 0, 0, 1);
    tests_run++;
    if (y_pad !== 10'd335 || moving !== 1'b1) begin
      fails++;
      $display("FAIL freeze_restart: y_pad=%0d moving=%b want 335/1",
               y_pad, moving);
    end
  endtask

  task automatic test_random();
    int len;
    int shown;
    logic u, d, f;
    do_reset();
    shown = 0;
    for (int s = 0; s < 150; s++) begin
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 9) == 0);
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        cyc(u, d, f, $urandom_range(0, 3) == 0);
        tests_run++;
        if (y_pad !== 10'(m_y) || moving !== (m_dir != 0)) begin
          fails++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random: y_pad=%0d moving=%b want %0d/%b",
                     y_pad, moving, m_y, m_dir != 0);
          end
        end
      end
    end
  endtask

`ifdef PADDLE_AI_EN
  task automatic test_ai();
    do_reset();
    ai_mode = 1;
    y_ball = 11'd600;
    frames(1, 0, 0, 200);
    tests_run++;
    if (y_pad < 10'd570 || y_pad > 10'd572 || moving !== 1'b0) begin
      fails++;
      $display("FAIL ai_track: y_pad=%0d moving=%b want 570..572/0",
               y_pad, moving);
    end
    ai_mode = 0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_accel();
    test_saturation();
    test_debounce();
    test_freeze();
`ifdef PADDLE_AI_EN
    test_ai();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
